// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: PC, one-outstanding memory read, FIFO toward decode
// A prefix word is held at the head until its suffix is buffered behind it.
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [0:63] RESET_ADDR = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [0:63] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [0:31] i_mem_data,
  input  logic        i_redirect,
  input  logic [0:63] i_redirect_addr,
  input  logic        i_stall,
  output logic        o_en,
  output logic [0:31] o_instr,
  output logic [0:63] o_instr_addr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO  = (AW+1)'(2);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q, state_d;
  logic [0:63]   pc_q, pc_d;
  logic [0:63]   req_addr_q, req_addr_d;
  logic [0:31]   buf_word [DEPTH];
  logic [0:63]   buf_addr [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, head_valid, head_is_prefix;
  logic [0:63]   redirect_pc;

  assign redirect_pc    = i_redirect_addr & ~64'h3;
  assign head_valid     = (count_q != '0);
  assign o_instr        = head_valid ? buf_word[rd_ptr_q] : '0;
  assign o_instr_addr   = head_valid ? buf_addr[rd_ptr_q] : '0;
  assign head_is_prefix = (o_instr[0:5] == 6'b000001);

  // A full FIFO always has count >= 2, so a prefix in the last slot still drains.
  assign o_en = !i_rst && !i_redirect && !i_stall && head_valid &&
                (!head_is_prefix || count_q >= TWO);
  assign pop  = o_en;
  assign push = (state_q == WAIT) && i_mem_ack && !i_redirect;

  assign count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign o_mem_req  = (state_q != IDLE);
  assign o_mem_addr = req_addr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (i_redirect) begin
          pc_d = redirect_pc;
        end else if (count_q < FULL) begin
          state_d    = WAIT;
          req_addr_d = pc_q;
        end
      end
      WAIT: begin
        if (i_redirect) begin
          pc_d    = redirect_pc;
          state_d = i_mem_ack ? IDLE : DROP;
        end else if (i_mem_ack) begin
          pc_d       = pc_q + 64'd4;
          req_addr_d = pc_q + 64'd4;
          state_d    = (count_d < FULL) ? WAIT : IDLE;
        end
      end
      DROP: begin
        // The stale request stays on the bus at its old address until acked.
        if (i_redirect) pc_d = redirect_pc;
        if (i_mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_ADDR;
      req_addr_q <= RESET_ADDR;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      if (i_redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        if (pop)  rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_word[wr_ptr_q] <= i_mem_data;
      buf_addr[wr_ptr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        i_clk;
  logic        i_rst;
  logic        o_mem_req;
  logic [0:63] o_mem_addr;
  logic        i_mem_ack;
  logic [0:31] i_mem_data;
  logic        i_redirect;
  logic [0:63] i_redirect_addr;
  logic        i_stall;
  logic        o_en;
  logic [0:31] o_instr;
  logic [0:63] o_instr_addr;

  int   n_pass;
  int   n_total;
  logic auto_ack;

  fetch_queue #(.DEPTH(4), .RESET_ADDR(64'h100)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
    .i_stall(i_stall), .o_en(o_en),
    .o_instr(o_instr), .o_instr_addr(o_instr_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance to just after the next rising edge; the memory model acks any open request.
  task tick;
    @(posedge i_clk);
    #1;
    if (auto_ack) begin
      i_mem_ack  = o_mem_req;
      i_mem_data = o_mem_addr[32:63];
    end
  endtask

  task settle;
    @(negedge i_clk);
  endtask

  task do_reset;
    auto_ack = 1'b0;
    tick;
    i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_mem_ack = 1'b0;
    tick;
    i_rst = 1'b0;
  endtask

  task test_reset;
    i_rst = 1'b1;
    tick;
    settle;
    n_total++; if (o_mem_req !== 1'b0) $display("FAIL reset_req got %b want 0", o_mem_req); else n_pass++;
    n_total++; if (o_en !== 1'b0) $display("FAIL reset_en got %b want 0", o_en); else n_pass++;
    n_total++; if (o_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", o_instr); else n_pass++;
    n_total++; if (o_instr_addr !== 64'h0) $display("FAIL reset_iaddr got %h want 0", o_instr_addr); else n_pass++;
  endtask

  task test_stream;
    logic [0:63] e;
    do_reset;
    settle;
    n_total++; if (o_mem_req !== 1'b0) $display("FAIL stream_idle_req got %b want 0", o_mem_req); else n_pass++;
    auto_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      settle;
      e = 64'h100 + 64'(4 * k);
      n_total++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== e)
        $display("FAIL stream_addr k=%0d got req=%b addr=%h want req=1 addr=%h", k, o_mem_req, o_mem_addr, e);
      else n_pass++;
      n_total++;
      if (o_en !== (k >= 1)) $display("FAIL stream_en k=%0d got %b want %b", k, o_en, (k >= 1));
      else n_pass++;
      if (k >= 1) begin
        e = 64'h100 + 64'(4 * (k - 1));
        n_total++;
        if (o_instr !== e[32:63] || o_instr_addr !== e)
          $display("FAIL stream_word k=%0d got %h@%h want %h@%h", k, o_instr, o_instr_addr, e[32:63], e);
        else n_pass++;
      end
    end
  endtask

  task test_stall;
    int          n_acks;
    logic        en_seen;
    logic [0:63] e;
    do_reset;
    i_stall = 1'b1;
    settle;
    auto_ack = 1'b1;
    n_acks = 0;
    en_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick;
      settle;
      if (o_mem_req && i_mem_ack) n_acks++;
      if (o_en) en_seen = 1'b1;
    end
    n_total++; if (n_acks != 4) $display("FAIL stall_acks got %0d want 4", n_acks); else n_pass++;
    n_total++; if (en_seen !== 1'b0) $display("FAIL stall_en got %b want 0", en_seen); else n_pass++;
    n_total++; if (o_mem_req !== 1'b0) $display("FAIL stall_req got %b want 0", o_mem_req); else n_pass++;
    for (int r = 0; r < 6; r++) begin
      tick;
      i_stall = 1'b0;
      settle;
      e = 64'h100 + 64'(4 * r);
      n_total++;
      if (o_en !== 1'b1 || o_instr !== e[32:63])
        $display("FAIL drain r=%0d got en=%b instr=%h want en=1 instr=%h", r, o_en, o_instr, e[32:63]);
      else n_pass++;
      if (r == 2) begin
        n_total++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h110)
          $display("FAIL resume_req got req=%b addr=%h want req=1 addr=0000000000000110", o_mem_req, o_mem_addr);
        else n_pass++;
      end
    end
  endtask

  task test_prefix;
    do_reset;
    i_redirect = 1'b1;
    i_redirect_addr = 64'h200;
    settle;
    tick;
    i_redirect = 1'b0;
    settle;
    tick;
    i_mem_ack = 1'b1;
    i_mem_data = 32'h04000000;
    settle;
    n_total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h200)
      $display("FAIL prefix_req got req=%b addr=%h want req=1 addr=0000000000000200", o_mem_req, o_mem_addr);
    else n_pass++;
    for (int k = 3; k < 8; k++) begin
      tick;
      i_mem_ack = (k == 7);
      i_mem_data = 32'h38600001;
      settle;
      n_total++; if (o_en !== 1'b0) $display("FAIL prefix_hold k=%0d got en=%b want 0", k, o_en); else n_pass++;
    end
    n_total++;
    if (o_mem_addr !== 64'h204) $display("FAIL suffix_addr got %h want 0000000000000204", o_mem_addr);
    else n_pass++;
    tick;
    i_mem_ack = 1'b0;
    settle;
    n_total++;
    if (o_en !== 1'b1 || o_instr !== 32'h04000000 || o_instr_addr !== 64'h200)
      $display("FAIL prefix_out got en=%b %h@%h want en=1 04000000@200", o_en, o_instr, o_instr_addr);
    else n_pass++;
    tick;
    settle;
    n_total++;
    if (o_en !== 1'b1 || o_instr !== 32'h38600001 || o_instr_addr !== 64'h204)
      $display("FAIL suffix_out got en=%b %h@%h want en=1 38600001@204", o_en, o_instr, o_instr_addr);
    else n_pass++;
  endtask

  task test_redirect_wait;
    do_reset;
    settle;
    tick;
    i_redirect = 1'b1;
    i_redirect_addr = 64'h4003;
    settle;
    n_total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h100)
      $display("FAIL redir_first_req got req=%b addr=%h want req=1 addr=100", o_mem_req, o_mem_addr);
    else n_pass++;
    for (int k = 2; k < 5; k++) begin
      tick;
      i_redirect = 1'b0;
      i_mem_ack = (k == 4);
      i_mem_data = 32'hDEADBEEF;
      settle;
      n_total++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h100 || o_en !== 1'b0)
        $display("FAIL drop_hold k=%0d got req=%b addr=%h en=%b want req=1 addr=100 en=0", k, o_mem_req, o_mem_addr, o_en);
      else n_pass++;
    end
    tick;
    i_mem_ack = 1'b0;
    settle;
    n_total++;
    if (o_mem_req !== 1'b0 || o_en !== 1'b0 || o_instr !== 32'h0)
      $display("FAIL drop_done got req=%b en=%b instr=%h want req=0 en=0 instr=0", o_mem_req, o_en, o_instr);
    else n_pass++;
    tick;
    i_mem_ack = 1'b1;
    i_mem_data = 32'h11111111;
    settle;
    n_total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h4000)
      $display("FAIL redir_new_req got req=%b addr=%h want req=1 addr=4000", o_mem_req, o_mem_addr);
    else n_pass++;
    tick;
    i_mem_ack = 1'b0;
    settle;
    n_total++;
    if (o_en !== 1'b1 || o_instr !== 32'h11111111 || o_instr_addr !== 64'h4000)
      $display("FAIL redir_word got en=%b %h@%h want en=1 11111111@4000", o_en, o_instr, o_instr_addr);
    else n_pass++;
  endtask

  task test_redirect_ack;
    do_reset;
    i_stall = 1'b1;
    settle;
    auto_ack = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick;
      settle;
    end
    tick;
    i_stall = 1'b0;
    i_redirect = 1'b1;
    i_redirect_addr = 64'h8000;
    settle;
    n_total++;
    if (o_en !== 1'b0 || o_instr !== 32'h100 || o_mem_req !== 1'b1)
      $display("FAIL redir_ack_cycle got en=%b instr=%h req=%b want en=0 instr=100 req=1", o_en, o_instr, o_mem_req);
    else n_pass++;
    tick;
    i_redirect = 1'b0;
    settle;
    n_total++;
    if (o_mem_req !== 1'b0 || o_en !== 1'b0 || o_instr !== 32'h0 || o_instr_addr !== 64'h0)
      $display("FAIL redir_flush got req=%b en=%b %h@%h want req=0 en=0 0@0", o_mem_req, o_en, o_instr, o_instr_addr);
    else n_pass++;
    tick;
    settle;
    n_total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h8000)
      $display("FAIL redir_ack_req got req=%b addr=%h want req=1 addr=8000", o_mem_req, o_mem_addr);
    else n_pass++;
    tick;
    settle;
    n_total++;
    if (o_en !== 1'b1 || o_instr !== 32'h8000 || o_instr_addr !== 64'h8000)
      $display("FAIL redir_ack_word got en=%b %h@%h want en=1 00008000@8000", o_en, o_instr, o_instr_addr);
    else n_pass++;
    auto_ack = 1'b0;
  endtask

  task test_reset_wait;
    do_reset;
    i_stall = 1'b1;
    settle;
    auto_ack = 1'b1;
    tick;
    settle;
    tick;
    settle;
    auto_ack = 1'b0;
    tick;
    i_mem_ack = 1'b0;
    i_rst = 1'b1;
    settle;
    n_total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h108)
      $display("FAIL rst_wait_req got req=%b addr=%h want req=1 addr=108", o_mem_req, o_mem_addr);
    else n_pass++;
    tick;
    i_rst = 1'b0;
    i_stall = 1'b0;
    settle;
    n_total++;
    if (o_mem_req !== 1'b0 || o_en !== 1'b0 || o_instr !== 32'h0)
      $display("FAIL rst_wait_after got req=%b en=%b instr=%h want req=0 en=0 instr=0", o_mem_req, o_en, o_instr);
    else n_pass++;
    tick;
    settle;
    n_total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h100)
      $display("FAIL rst_wait_restart got req=%b addr=%h want req=1 addr=100", o_mem_req, o_mem_addr);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    auto_ack = 1'b0;
    i_rst = 1'b1;
    i_mem_ack = 1'b0;
    i_mem_data = '0;
    i_redirect = 1'b0;
    i_redirect_addr = '0;
    i_stall = 1'b0;
    test_reset;
    test_stream;
    test_stall;
    test_prefix;
    test_redirect_wait;
    test_redirect_ack;
    test_reset_wait;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
